// File: rtl/grid_mem_rows_if.sv
// Port bundle for grid_mem_rows: game-logic port A, display port B and the
// clear/collapse engine controls, with the memory acting as the slave.
interface grid_mem_rows_if #(
  parameter int ROW_WIDTH  = 10,
  parameter int ADDR_WIDTH = 5
);
  logic [ROW_WIDTH-1:0]  data_a;
  logic [ADDR_WIDTH-1:0] addr_a;
  logic                  we_a;
  logic [ADDR_WIDTH-1:0] addr_b;
  logic                  clr_req;
  logic                  collapse_req;
  logic [ADDR_WIDTH-1:0] collapse_row;
  logic [ROW_WIDTH-1:0]  q_a;
  logic [ROW_WIDTH-1:0]  q_b;
  logic                  full_a;
  logic                  busy;
  logic                  done;

  modport master (
    output data_a, addr_a, we_a, addr_b, clr_req, collapse_req, collapse_row,
    input  q_a, q_b, full_a, busy, done
  );

  modport slave (
    input  data_a, addr_a, we_a, addr_b, clr_req, collapse_req, collapse_row,
    output q_a, q_b, full_a, busy, done
  );
endinterface

// File: rtl/grid_mem_rows.sv
// Row-organised Tetris playfield memory: registered dual-port access plus a
// sequential clear sweep and a line-collapse engine sharing one write port.
module grid_mem_rows #(
  parameter int ROW_WIDTH  = 10,
  parameter int ADDR_WIDTH = 5,
  parameter int ROWS       = 20
) (
  input  logic           clk,
  input  logic           reset,
  grid_mem_rows_if.slave bus
);

  localparam logic [ADDR_WIDTH:0]   ROWS_EXT = (ADDR_WIDTH+1)'(ROWS);
  localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'(ROWS - 1);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    COLLAPSE
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [ADDR_WIDTH-1:0] cnt_next;
  logic                  busy;
  logic                  done;
  logic                  done_next;
  logic [ROW_WIDTH-1:0]  q_a;
  logic [ROW_WIDTH-1:0]  q_b;

  logic [ROW_WIDTH-1:0]  mem [0:ROWS-1];

  logic                  eng_we;
  logic [ROW_WIDTH-1:0]  eng_data;
  logic                  addr_a_ok;
  logic                  addr_b_ok;
  logic                  row_ok;
  logic                  wr_a;

  assign addr_a_ok = {1'b0, bus.addr_a} < ROWS_EXT;
  assign addr_b_ok = {1'b0, bus.addr_b} < ROWS_EXT;
  assign row_ok    = {1'b0, bus.collapse_row} < ROWS_EXT;
  // Port A may only write while the engine is parked, so the array never sees two writers.
  assign wr_a      = bus.we_a && addr_a_ok && (state == IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= CLEAR;
      cnt   <= '0;
      busy  <= 1'b1;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      busy  <= (state_next != IDLE);
      done  <= done_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    done_next  = 1'b0;
    eng_we     = 1'b0;
    eng_data   = '0;
    case (state)
      IDLE: begin
        if (bus.clr_req) begin
          state_next = CLEAR;
          cnt_next   = '0;
        end else if (bus.collapse_req && row_ok) begin
          state_next = COLLAPSE;
          cnt_next   = bus.collapse_row;
        end
      end
      CLEAR: begin
        eng_we = 1'b1;
        if (cnt == LAST_ROW) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      COLLAPSE: begin
        // Walk upward from the removed row, pulling each row above it down; row 0 is blanked last.
        eng_we = 1'b1;
        if (cnt != '0) begin
          eng_data = mem[cnt - 1'b1];
          cnt_next = cnt - 1'b1;
        end else begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (eng_we) begin
      mem[cnt] <= eng_data;
    end else if (wr_a) begin
      mem[bus.addr_a] <= bus.data_a;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_a <= '0;
      q_b <= '0;
    end else begin
      if (wr_a) begin
        q_a <= bus.data_a;
      end else if (addr_a_ok) begin
        q_a <= mem[bus.addr_a];
      end else begin
        q_a <= '0;
      end
      if (wr_a && (bus.addr_b == bus.addr_a)) begin
        q_b <= bus.data_a;
      end else if (addr_b_ok) begin
        q_b <= mem[bus.addr_b];
      end else begin
        q_b <= '0;
      end
    end
  end

  assign bus.q_a    = q_a;
  assign bus.q_b    = q_b;
  assign bus.full_a = &q_a;
  assign bus.busy   = busy;
  assign bus.done   = done;

endmodule
